imem_loader: RTL

- Boot-time writer for the instruction memory, which the single-cycle core only reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes them to consecutive word addresses starting at BASE_ADDR.
- Holds the core in reset while loading; releases it when the programmed word count has been written.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_assembler.sv | 31 +++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Optional checksum feature: IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    FIN,
    CSUM
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_STEP  = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; word shows the
// incoming byte merged in so a full word is visible on word_full.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        byte_data,
  output logic [31:0]       word,
  output logic              word_full
);

  logic [31:0] held;

  assign word_full = load && (lane == LANE_W'(WORD_BYTES - 1));

  // overlay the byte being accepted onto the stored lanes
  always_comb begin
    word = held;
    if (load) word[{lane, 3'b000} +: 8] = byte_data;
  end

  // capture each accepted byte into its lane
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) held <= '0;
    else if (load) held[{lane, 3'b000} +: 8] <= byte_data;
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader; holds the core while loading.
// Optional checksum trailer: define IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                LEN_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic              csum_err
`endif
);

  state_t              state;
  logic [LANE_W-1:0]   lane;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_cnt;
  logic                accept;
  logic                data_load;
  logic                data_full;

  assign accept    = byte_valid && byte_ready;
  assign data_load = accept && (state == RECV);

  byte_assembler u_data (
    .clk       (clk),
    .reset     (reset),
    .load      (data_load),
    .lane      (lane),
    .byte_data (byte_data),
    .word      (wr_data),
    .word_full (data_full)
  );

`ifdef IMEM_LOADER_CSUM_EN
  logic [31:0] sum;
  logic [31:0] rx_sum;
  logic        sum_load;
  logic        sum_full;
  logic        sum_bad;

  assign sum_load = accept && (state == CSUM);
  assign sum_bad  = (rx_sum != sum);

  byte_assembler u_csum (
    .clk       (clk),
    .reset     (reset),
    .load      (sum_load),
    .lane      (lane),
    .byte_data (byte_data),
    .word      (rx_sum),
    .word_full (sum_full)
  );
`endif

  // load sequencer with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      lane       <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum        <= '0;
      csum_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) lane <= lane + LANE_W'(1);
      unique case (state)
        IDLE: begin
          if (start) begin
`ifdef IMEM_LOADER_CSUM_EN
            sum      <= '0;
            csum_err <= 1'b0;
`endif
            if (len_words != '0) begin
              len_q      <= len_words;
              wr_addr    <= BASE_ADDR;
              lane       <= '0;
              word_cnt   <= '0;
              cpu_hold   <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= RECV;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RECV: begin
          if (data_full) begin
            byte_ready <= 1'b0;
            wr_en      <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          wr_en    <= 1'b0;
          wr_addr  <= wr_addr + ADDR_W'(ADDR_STEP);
          word_cnt <= word_cnt + LEN_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
          sum      <= sum + wr_data;
`endif
          if (word_cnt + LEN_W'(1) == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
            byte_ready <= 1'b1;
            state      <= CSUM;
`else
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            state    <= FIN;
`endif
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        CSUM: begin
          if (sum_full) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            csum_err   <= sum_bad;
            cpu_hold   <= sum_bad;
            state      <= FIN;
          end
        end
`endif
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
